// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser plus stability filter for noisy
// buttons and switches. Each channel yields a debounced level, single-cycle
// rise/fall events, a push-on/push-off toggle, and a shared registered
// any_event flag for consumers that only need to know "something happened".
module debounce_multi #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 3,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] tgl,
    output logic                any_event
);

    localparam int CW = (STABLE_CYCLES + 1 > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    // Terminal count: out changes on the edge where the mismatch has been
    // seen for STABLE_CYCLES consecutive edges, so the counter tops out here.
    localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CHANNELS-1:0] s;

    assign s = sync_q[SYNC_STAGES-1];

    // Input synchroniser chain, all channels in parallel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {CHANNELS{RESET_LEVEL}};
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-channel stability counter; a match with out restarts the count,
    // reaching the terminal count commits the new level and emits an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= {CHANNELS{RESET_LEVEL}};
            rise <= '0;
            fall <= '0;
            tgl  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (s[i] == out[i]) begin
                    cnt_q[i] <= '0;
                    rise[i]  <= 1'b0;
                    fall[i]  <= 1'b0;
                end else if (cnt_q[i] == CNT_TC) begin
                    out[i]   <= s[i];
                    cnt_q[i] <= '0;
                    rise[i]  <= s[i];
                    fall[i]  <= ~s[i];
                    if (s[i]) begin
                        tgl[i] <= ~tgl[i];
                    end
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                    rise[i]  <= 1'b0;
                    fall[i]  <= 1'b0;
                end
            end
        end
    end

    // Summary event flag, one cycle behind the per-channel pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |(rise | fall);
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi. The reference model decides each
// output change from a sliding window over the recorded input history:
// out flips at an edge when the synchronised input has disagreed with out on
// each of the last STABLE_CYCLES edges since the previous event or reset.
module tb_debounce_multi;

    localparam int   CH   = 4;
    localparam int   ST   = 3;
    localparam int   SS   = 2;
    localparam logic RL   = 1'b0;
    localparam int   HMAX = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] in_drv;
    logic [CH-1:0] out, rise, fall, tgl;
    logic          any_event;

    int vectors = 0;
    int errors  = 0;

    debounce_multi #(
        .CHANNELS(CH), .STABLE_CYCLES(ST), .SYNC_STAGES(SS), .RESET_LEVEL(RL)
    ) dut (
        .clk(clk), .rst(rst), .in(in_drv), .out(out), .rise(rise),
        .fall(fall), .tgl(tgl), .any_event(any_event)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [CH-1:0] in_hist  [HMAX];
    bit            rst_hist [HMAX];
    int            last_evt [CH];
    int            n = 0;
    logic [CH-1:0] m_out, m_rise, m_fall, m_tgl;
    logic          m_any;

    // value the last synchroniser stage presents just before edge j
    function automatic logic s_at(int j, int ch);
        if (j - SS < 0) return RL;
        for (int e = j - SS; e <= j - 1; e++)
            if (rst_hist[e]) return RL;
        return in_hist[j-SS][ch];
    endfunction

    always @(posedge clk) begin : model
        bit stable;
        if (n < HMAX) begin
            in_hist[n]  = in_drv;
            rst_hist[n] = rst;
            if (rst) begin
                m_out  = {CH{RL}};
                m_rise = '0;
                m_fall = '0;
                m_tgl  = '0;
                m_any  = 1'b0;
                for (int ch = 0; ch < CH; ch++) last_evt[ch] = n;
            end else begin
                m_any = |(m_rise | m_fall);
                for (int ch = 0; ch < CH; ch++) begin
                    stable = 1'b1;
                    for (int j = n - ST + 1; j <= n; j++)
                        if (j <= last_evt[ch] || s_at(j, ch) == m_out[ch]) stable = 1'b0;
                    m_rise[ch] = 1'b0;
                    m_fall[ch] = 1'b0;
                    if (stable) begin
                        m_out[ch]  = ~m_out[ch];
                        m_rise[ch] = m_out[ch];
                        m_fall[ch] = ~m_out[ch];
                        if (m_out[ch]) m_tgl[ch] = ~m_tgl[ch];
                        last_evt[ch] = n;
                    end
                end
            end
            n++;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst    = 1'b1;
        in_drv = '1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if ({out, rise, fall, tgl, any_event} !== '0) begin
                errors++;
                $display("FAIL reset_state t=%0t got out=%b rise=%b fall=%b tgl=%b any=%b want all 0",
                         $time, out, rise, fall, tgl, any_event);
            end
        end
        in_drv = '0;
        rst    = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_clean_press;
        in_drv[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if ({out, rise, fall, tgl, any_event} !== {m_out, m_rise, m_fall, m_tgl, m_any}) begin
                errors++;
                $display("FAIL model_clean t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time,
                         out, rise, fall, tgl, any_event, m_out, m_rise, m_fall, m_tgl, m_any);
            end
            vectors++;
            if ({out[0], rise[0], any_event} !== {1'(i >= 4), 1'(i == 4), 1'(i == 5)}) begin
                errors++;
                $display("FAIL clean_press_timing edge=k+%0d got out0=%b rise0=%b any=%b want %b %b %b",
                         i, out[0], rise[0], any_event, i >= 4, i == 4, i == 5);
            end
        end
        vectors++;
        if (tgl[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_press_tgl got %b want 1", tgl[0]);
        end
        in_drv[0] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic bounce_drive(input logic final_v);
        int el;
        int d;
        el = 0;
        while (el < 20) begin
            d = int'($urandom_range(4, 3));
            if ((($time + d) % 10) == 5) d = 7 - d;
            #d;
            in_drv[1] = ~in_drv[1];
            el += d;
        end
        in_drv[1] = final_v;
    endtask

    task automatic test_bounce;
        int rises;
        int falls;
        for (int phase = 0; phase < 2; phase++) begin
            rises = 0;
            falls = 0;
            fork
                bounce_drive(phase == 0 ? 1'b1 : 1'b0);
                begin
                    for (int i = 0; i < 12; i++) begin
                        @(negedge clk);
                        if (rise[1]) rises++;
                        if (fall[1]) falls++;
                        vectors++;
                        if ({out, rise, fall, tgl, any_event} !== {m_out, m_rise, m_fall, m_tgl, m_any}) begin
                            errors++;
                            $display("FAIL model_bounce t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time,
                                     out, rise, fall, tgl, any_event, m_out, m_rise, m_fall, m_tgl, m_any);
                        end
                    end
                end
            join
            vectors++;
            if (rises !== (phase == 0 ? 1 : 0) || falls !== (phase == 0 ? 0 : 1)) begin
                errors++;
                $display("FAIL bounce_event_count phase=%0d got rises=%0d falls=%0d want %0d %0d",
                         phase, rises, falls, phase == 0 ? 1 : 0, phase == 0 ? 0 : 1);
            end
        end
    endtask

    task automatic test_glitch;
        in_drv[2] = 1'b1;
        repeat (2) @(negedge clk);
        in_drv[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if ({out[2], rise[2], fall[2]} !== 3'b000) begin
                errors++;
                $display("FAIL glitch_reject t=%0t got out2=%b rise2=%b fall2=%b want 0 0 0",
                         $time, out[2], rise[2], fall[2]);
            end
        end
        // a full-length press after the glitch must still take the whole count
        in_drv[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({out[2], rise[2]} !== {1'(i >= 4), 1'(i == 4)}) begin
                errors++;
                $display("FAIL glitch_count_cleared edge=k+%0d got out2=%b rise2=%b want %b %b",
                         i, out[2], rise[2], i >= 4, i == 4);
            end
        end
        in_drv[2] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_multi_toggle;
        rst    = 1'b1;
        in_drv = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int step = 0; step < 4; step++) begin
            case (step)
                0: in_drv = 4'b1001;
                1: in_drv = 4'b1000;
                2: in_drv = 4'b1001;
                default: in_drv = 4'b0000;
            endcase
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                vectors++;
                if ({out, rise, fall, tgl, any_event} !== {m_out, m_rise, m_fall, m_tgl, m_any}) begin
                    errors++;
                    $display("FAIL model_multi t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time,
                             out, rise, fall, tgl, any_event, m_out, m_rise, m_fall, m_tgl, m_any);
                end
                if (step == 0) begin
                    vectors++;
                    if ({rise[0], rise[3]} !== {2{1'(i == 4)}}) begin
                        errors++;
                        $display("FAIL multi_aligned_rise edge=k+%0d got rise0=%b rise3=%b want %b",
                                 i, rise[0], rise[3], i == 4);
                    end
                end
            end
            if (step == 0 || step == 2) begin
                vectors++;
                if ({tgl[0], tgl[3]} !== {(step == 0) ? 1'b1 : 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL multi_toggle step=%0d got tgl0=%b tgl3=%b want %b 1",
                             step, tgl[0], tgl[3], step == 0);
                end
            end
        end
    endtask

    task automatic test_reset_midcount;
        in_drv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            if (i == 2) rst = 1'b0;
            vectors++;
            if ({out[0], rise[0], fall[0]} !== {1'(i >= 7), 1'(i == 7), 1'b0}) begin
                errors++;
                $display("FAIL reset_midcount edge=k+%0d got out0=%b rise0=%b fall0=%b want %b %b 0",
                         i, out[0], rise[0], fall[0], i >= 7, i == 7);
            end
        end
        in_drv[0] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random;
        int hold [CH];
        for (int ch = 0; ch < CH; ch++) hold[ch] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            vectors++;
            if ({out, rise, fall, tgl, any_event} !== {m_out, m_rise, m_fall, m_tgl, m_any}) begin
                errors++;
                $display("FAIL model_random t=%0t got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", $time,
                         out, rise, fall, tgl, any_event, m_out, m_rise, m_fall, m_tgl, m_any);
            end
            vectors++;
            if ((rise & fall) !== '0) begin
                errors++;
                $display("FAIL rise_fall_exclusive t=%0t got rise=%b fall=%b want disjoint", $time, rise, fall);
            end
            rst = ($urandom_range(99) == 0);
            for (int ch = 0; ch < CH; ch++) begin
                if (hold[ch] == 0) begin
                    in_drv[ch] = 1'($urandom_range(1));
                    hold[ch]   = int'($urandom_range(6, 1));
                end else begin
                    hold[ch]--;
                end
            end
        end
        rst    = 1'b0;
        in_drv = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_multi_toggle();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-bit debouncer, for noisy push-buttons and switches on the board.
- Each channel has its own input synchroniser and a stability counter.
- Per channel it produces a debounced level, one-cycle rise/fall event pulses and a push-on/push-off toggle state.
- It sits between the raw pad inputs and the user logic (counters, FSMs) that consume button events.

Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- STABLE_CYCLES, 3: consecutive clk cycles the synchronised input must differ from out before out changes (≥1).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (≥2).
- RESET_LEVEL, 0: 1-bit value loaded into synchroniser flops and out on reset; also the idle level of the inputs.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- out  out  CHANNELS  debounced level per channel.
- rise  out  CHANNELS  one-cycle pulse when out[i] goes 0→1.
- fall  out  CHANNELS  one-cycle pulse when out[i] goes 1→0.
- tgl  out  CHANNELS  toggle state; flips on every rise[i].
- any_event  out  1  registered OR of all rise and fall bits.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All synchroniser flops and out load RESET_LEVEL.
  - Counters, rise, fall, tgl and any_event load 0.
  - Reset mid-count discards the partial count; no pulse is produced by reset itself.
- Synchroniser: s[i] is the last stage of a SYNC_STAGES-deep shift chain fed by in[i].
- Counter width: $clog2(STABLE_CYCLES+1), one counter per channel. Channels are fully independent.
- Per-channel update on every non-reset edge, evaluated in this order:
  - s==out: cnt←0; rise, fall←0.
  - s!=out and cnt==STABLE_CYCLES-1: out←s; cnt←0; rise←s; fall←~s; if s==1, tgl←~tgl.
  - Otherwise: cnt←cnt+1; rise, fall←0.
- Glitch rejection: any cycle where s matches out restarts the count from 0. A glitch shorter than STABLE_CYCLES synchronised cycles never reaches out.
- Latency: if in[i] changes before edge k and then holds, s changes at edge k+SYNC_STAGES-1 and out changes at edge k+SYNC_STAGES-1+STABLE_CYCLES. rise/fall assert on that same edge for exactly 1 cycle.
- STABLE_CYCLES=1: out follows s with 1 extra cycle of delay; there is no filtering.
- Counter never wraps: it is cleared on the terminal count or on a match, so the maximum value reached is STABLE_CYCLES-1.
- any_event: registered one cycle after the rise/fall pulses, i.e. any_event(t+1) = |(rise(t)|fall(t)).
- rise and fall are never both 1 on the same channel in the same cycle.
- Simultaneous events on several channels each pulse independently in the same cycle.

Test Plan:
- Reset: CHANNELS=4, STABLE_CYCLES=3, SYNC_STAGES=2, RESET_LEVEL=0; rst=1 for 2 cycles with in=4'hF → out=0, rise=0, fall=0, tgl=0, any_event=0 while reset is held.
- Clean press: in[0] 0→1 before edge k, then held → out[0]=1 and rise[0]=1 at edge k+4; rise[0]=0 at k+5; tgl[0]=1; any_event=1 at k+5 only.
- Bounce rejection: in[1] toggles every 3–4 ns for 20 ns (10 ns clk), then settles at 1 → no rise[1] during the bounce; exactly one rise[1] 4 edges after the last sampled transition. Release bounce then gives exactly one fall[1].
- Short glitch: in[2] high for 2 clk cycles then low → out[2] stays 0; rise[2] and fall[2] never assert; counter ends at 0.
- Toggle and multi-channel: press/release ch0 twice while pressing ch3 once, with the ch0 and ch3 presses aligned → tgl[0] goes 1 then 0, tgl[3]=1; rise[0] and rise[3] pulse in the same cycle.
- Reset mid-count: in[0]=1 held, rst=1 at edge k+2 for 1 cycle → out[0]=0 after reset. The count restarts; out[0]=1 at edge (reset-release edge)+4, with no pulse caused by reset.
